// File: rtl/pueo_mode1_pkg.sv
// Shared types and constants for the mode1 command parser.
// MODE1_CMD_CHECKSUM_EN selects 8-byte frames with a trailing checksum byte; otherwise frames are 7 bytes.
package pueo_mode1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CKSUM,
    ST_DISCARD
  } state_e;

  localparam logic [2:0] ERR_SHORT   = 3'd0;
  localparam logic [2:0] ERR_LONG    = 3'd1;
  localparam logic [2:0] ERR_CKSUM   = 3'd2;
  localparam logic [2:0] ERR_OVF     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

`ifdef MODE1_CMD_CHECKSUM_EN
  localparam int PKT_LEN = 8;
`else
  localparam int PKT_LEN = 7;
`endif

  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);
  localparam int WR_BIT = 7;

endpackage

// File: rtl/mode1_sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-high reset.
module mode1_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Sticks at all-ones instead of wrapping so software sees "at least this many".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mode1_cmd_parser.sv
// Assembles mode1 byte frames into single-slot register read/write requests; drops and counts bad frames.
// Define MODE1_CMD_CHECKSUM_EN for 8-byte frames with checksum; default build uses 7-byte frames.
module mode1_cmd_parser
  import pueo_mode1_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 sysclk_i,
  input  logic                 rst_i,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_wr_o,
  output logic [15:0]          req_addr_o,
  output logic [31:0]          req_data_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o,
  output logic [CNT_WIDTH-1:0] pkt_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          wr_q, wr_d;
  logic          badCmd_q, badCmd_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
`ifdef MODE1_CMD_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d, newSum;
`endif

  logic          reqValid_q, reqWr_q;
  logic [15:0]   reqAddr_q;
  logic [31:0]   reqData_q;
  logic          err_q;
  logic [2:0]    errCode_q;

  logic          errDet;
  logic [2:0]    errDetCode;
  logic          loadReq;
  logic          badPkt;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    idle_d     = '0;
    wr_d       = wr_q;
    badCmd_d   = badCmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    errDet     = 1'b0;
    errDetCode = errCode_q;
    loadReq    = 1'b0;
`ifdef MODE1_CMD_CHECKSUM_EN
    sum_d      = sum_q;
    newSum     = sum_q + s_tdata;
    badPkt     = badCmd_q || (newSum != 8'd0);
`else
    badPkt     = badCmd_q;
`endif

    if (s_tvalid) begin
      if (state_q == ST_DISCARD) begin
        if (s_tlast) state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + 3'd1;
`ifdef MODE1_CMD_CHECKSUM_EN
        sum_d = newSum;
`endif
        if (idx_q == 3'd0) begin
          wr_d     = s_tdata[WR_BIT];
          badCmd_d = (s_tdata[6:0] != 7'd0);
          state_d  = ST_HDR;
        end else if (idx_q <= 3'd2) begin
          addr_d = {addr_q[7:0], s_tdata};
          if (idx_q == 3'd2) state_d = ST_DATA;
        end else if (idx_q <= 3'd6) begin
          data_d = {data_q[23:0], s_tdata};
`ifdef MODE1_CMD_CHECKSUM_EN
          if (idx_q == 3'd6) state_d = ST_CKSUM;
`endif
        end

        // Reserved-bit violations are held until the final byte so a frame raises at most one error.
        if (idx_q == LAST_IDX) begin
          if (!s_tlast) begin
            errDet     = 1'b1;
            errDetCode = ERR_LONG;
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_IDLE;
            if (badPkt) begin
              errDet     = 1'b1;
              errDetCode = ERR_CKSUM;
            end else if (reqValid_q && !req_ready_i) begin
              errDet     = 1'b1;
              errDetCode = ERR_OVF;
            end else begin
              loadReq = 1'b1;
            end
          end
        end else if (s_tlast) begin
          errDet     = 1'b1;
          errDetCode = ERR_SHORT;
          state_d    = ST_IDLE;
        end
      end
    end else if (state_q != ST_IDLE) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        if (state_q != ST_DISCARD) begin
          errDet     = 1'b1;
          errDetCode = ERR_TIMEOUT;
        end
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end

    if (state_d == ST_IDLE) begin
      idx_d = 3'd0;
`ifdef MODE1_CMD_CHECKSUM_EN
      sum_d = 8'd0;
`endif
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      idle_q     <= '0;
      wr_q       <= 1'b0;
      badCmd_q   <= 1'b0;
      addr_q     <= 16'd0;
      data_q     <= 32'd0;
`ifdef MODE1_CMD_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
      reqValid_q <= 1'b0;
      reqWr_q    <= 1'b0;
      reqAddr_q  <= 16'd0;
      reqData_q  <= 32'd0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_SHORT;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      idle_q     <= idle_d;
      wr_q       <= wr_d;
      badCmd_q   <= badCmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef MODE1_CMD_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
      // A load in the same cycle as a handshake replaces the departing request.
      if (loadReq) begin
        reqValid_q <= 1'b1;
        reqWr_q    <= wr_d;
        reqAddr_q  <= addr_d;
        reqData_q  <= data_d;
      end else if (req_ready_i) begin
        reqValid_q <= 1'b0;
      end
      err_q <= errDet;
      if (errDet) errCode_q <= errDetCode;
    end
  end

  mode1_sat_counter #(.WIDTH(CNT_WIDTH)) uPktCount (
    .clk_i   (sysclk_i),
    .rst_i   (rst_i),
    .inc_i   (loadReq),
    .count_o (pkt_count_o)
  );

  mode1_sat_counter #(.WIDTH(CNT_WIDTH)) uErrCount (
    .clk_i   (sysclk_i),
    .rst_i   (rst_i),
    .inc_i   (errDet),
    .count_o (err_count_o)
  );

  assign s_tready    = 1'b1;
  assign req_valid_o = reqValid_q;
  assign req_wr_o    = reqWr_q;
  assign req_addr_o  = reqAddr_q;
  assign req_data_o  = reqData_q;
  assign err_o       = err_q;
  assign err_code_o  = errCode_q;

endmodule

// File: tb/tb_mode1_cmd_parser.sv
// Testbench for mode1_cmd_parser: directed and random frames checked every cycle against a frame-level model.
// Frame length follows MODE1_CMD_CHECKSUM_EN exactly as the design does.
module tb_mode1_cmd_parser;

  localparam int CW   = 4;
  localparam int TO   = 1023;
  localparam int MAXC = (1 << CW) - 1;
`ifdef MODE1_CMD_CHECKSUM_EN
  localparam int PLEN = 8;
  localparam bit CK   = 1'b1;
`else
  localparam int PLEN = 7;
  localparam bit CK   = 1'b0;
`endif

  logic          sysclk_i;
  logic          rst_i;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          req_valid_o;
  logic          req_ready_i;
  logic          req_wr_o;
  logic [15:0]   req_addr_o;
  logic [31:0]   req_data_o;
  logic          err_o;
  logic [2:0]    err_code_o;
  logic [CW-1:0] pkt_count_o;
  logic [CW-1:0] err_count_o;

  mode1_cmd_parser #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .sysclk_i    (sysclk_i),
    .rst_i       (rst_i),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_wr_o    (req_wr_o),
    .req_addr_o  (req_addr_o),
    .req_data_o  (req_data_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .pkt_count_o (pkt_count_o),
    .err_count_o (err_count_o)
  );

  initial sysclk_i = 1'b0;
  always #4 sysclk_i = ~sysclk_i;

  int checks = 0;
  int errors = 0;

  logic readyDrv  = 1'b1;
  logic rstDrv    = 1'b0;
  logic randReady = 1'b0;
  logic [7:0] frm[$];

  // Frame-level reference: bytes collect until the frame resolves, then the outcome follows from length, sum and slot state.
  logic [7:0]  mq[$];
  logic        mDiscard = 1'b0;
  int          mIdle    = 0;
  logic        mErr     = 1'b0;
  logic [2:0]  mCode    = 3'd0;
  int          mPkt     = 0;
  int          mErrCnt  = 0;
  logic        mValid   = 1'b0;
  logic        mWr      = 1'b0;
  logic [15:0] mAddr    = 16'd0;
  logic [31:0] mData    = 32'd0;

  task automatic modelEdge(input logic [7:0] d, input logic v, input logic l,
                           input logic rdy, input logic rst);
    logic errNow;
    logic [2:0] code;
    logic load;
    logic [7:0] sum;
    logic reserved;
    errNow = 1'b0;
    code   = 3'd0;
    load   = 1'b0;
    if (rst) begin
      mq.delete();
      mDiscard = 1'b0; mIdle = 0; mErr = 1'b0; mCode = 3'd0;
      mPkt = 0; mErrCnt = 0; mValid = 1'b0; mWr = 1'b0; mAddr = 16'd0; mData = 32'd0;
    end else begin
      if (!v && (mq.size() > 0 || mDiscard)) begin
        mIdle++;
        if (mIdle == TO) begin
          if (!mDiscard) begin errNow = 1'b1; code = 3'd4; end
          mq.delete();
          mDiscard = 1'b0;
          mIdle = 0;
        end
      end
      if (v) begin
        mIdle = 0;
        if (mDiscard) begin
          if (l) mDiscard = 1'b0;
        end else begin
          mq.push_back(d);
          if (mq.size() == PLEN && !l) begin
            errNow = 1'b1; code = 3'd1; mDiscard = 1'b1; mq.delete();
          end else if (l && mq.size() < PLEN) begin
            errNow = 1'b1; code = 3'd0; mq.delete();
          end else if (l) begin
            sum = 8'd0;
            foreach (mq[i]) sum = sum + mq[i];
            reserved = (mq[0][6:0] != 7'd0);
            if (reserved || (CK && sum != 8'd0)) begin
              errNow = 1'b1; code = 3'd2;
            end else if (mValid && !rdy) begin
              errNow = 1'b1; code = 3'd3;
            end else begin
              load  = 1'b1;
              mWr   = mq[0][7];
              mAddr = {mq[1], mq[2]};
              mData = {mq[3], mq[4], mq[5], mq[6]};
            end
            mq.delete();
          end
        end
      end
      if (load) mValid = 1'b1;
      else if (rdy) mValid = 1'b0;
      mErr = errNow;
      if (errNow) begin
        mCode = code;
        if (mErrCnt < MAXC) mErrCnt++;
      end
      if (load && mPkt < MAXC) mPkt++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("s_tready", 32'(s_tready), 32'd1);
    checkOutput("req_valid_o", 32'(req_valid_o), 32'(mValid));
    checkOutput("req_wr_o", 32'(req_wr_o), 32'(mWr));
    checkOutput("req_addr_o", 32'(req_addr_o), 32'(mAddr));
    if (mWr) checkOutput("req_data_o", req_data_o, mData);
    checkOutput("err_o", 32'(err_o), 32'(mErr));
    checkOutput("err_code_o", 32'(err_code_o), 32'(mCode));
    checkOutput("pkt_count_o", 32'(pkt_count_o), 32'(mPkt));
    checkOutput("err_count_o", 32'(err_count_o), 32'(mErrCnt));
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l);
    logic rdy;
    rdy = randReady ? 1'($urandom) : readyDrv;
    s_tdata     = d;
    s_tvalid    = v;
    s_tlast     = l;
    req_ready_i = rdy;
    rst_i       = rstDrv;
    @(posedge sysclk_i);
    modelEdge(d, v, l, rdy, rstDrv);
    @(negedge sysclk_i);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'($urandom), 1'b0, 1'($urandom));
  endtask

  // Sends frm with the given byte spacing; the last byte carries tlast only when withLast is set.
  task automatic sendFrame(input int gap, input logic withLast);
    for (int i = 0; i < frm.size(); i++) begin
      applyStimulus(frm[i], 1'b1, withLast && (i == frm.size() - 1));
      if (i != frm.size() - 1) idleCycles(gap - 1);
    end
  endtask

  task automatic buildGood(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    logic [7:0] sum;
    frm.delete();
    frm.push_back(wr ? 8'h80 : 8'h00);
    frm.push_back(addr[15:8]);
    frm.push_back(addr[7:0]);
    frm.push_back(data[31:24]);
    frm.push_back(data[23:16]);
    frm.push_back(data[15:8]);
    frm.push_back(data[7:0]);
    if (CK) begin
      sum = 8'd0;
      foreach (frm[i]) sum = sum + frm[i];
      frm.push_back(8'(8'd0 - sum));
    end
  endtask

  task automatic buildRandom(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  initial begin
    int kind;
    s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; req_ready_i = 1'b1; rst_i = 1'b1;
    @(negedge sysclk_i);

    $display("[TB] reset");
    rstDrv = 1'b1;
    idleCycles(2);
    rstDrv = 1'b0;
    checkOutput("rst_valid", 32'(req_valid_o), 32'd0);
    checkOutput("rst_pkt_count", 32'(pkt_count_o), 32'd0);
    idleCycles(3);

    $display("[TB] good write packet");
    readyDrv = 1'b1;
    buildGood(1'b1, 16'h0010, 32'hDEADBEEF);
    sendFrame(8, 1'b1);
    checkOutput("plan_valid", 32'(req_valid_o), 32'd1);
    checkOutput("plan_wr", 32'(req_wr_o), 32'd1);
    checkOutput("plan_addr", 32'(req_addr_o), 32'h0010);
    checkOutput("plan_data", req_data_o, 32'hDEADBEEF);
    checkOutput("plan_pkt_count", 32'(pkt_count_o), 32'd1);
    idleCycles(1);
    checkOutput("plan_valid_drop", 32'(req_valid_o), 32'd0);
    idleCycles(8);

    $display("[TB] bad checksum / reserved bits");
    buildGood(1'b1, 16'h0010, 32'hDEADBEEF);
    if (CK) frm[PLEN-1] = frm[PLEN-1] + 8'd1;
    else frm[0] = 8'h81;
    sendFrame(8, 1'b1);
    checkOutput("cksum_err", 32'(err_o), 32'd1);
    checkOutput("cksum_code", 32'(err_code_o), 32'd2);
    checkOutput("cksum_err_count", 32'(err_count_o), 32'd1);
    checkOutput("cksum_no_req", 32'(req_valid_o), 32'd0);
    idleCycles(8);

    $display("[TB] short frame then good read");
    frm.delete();
    frm.push_back(8'h80); frm.push_back(8'h00); frm.push_back(8'h10);
    sendFrame(8, 1'b1);
    checkOutput("short_code", 32'(err_code_o), 32'd0);
    idleCycles(8);
    buildGood(1'b0, 16'h1234, 32'h0);
    sendFrame(8, 1'b1);
    checkOutput("after_short_addr", 32'(req_addr_o), 32'h1234);
    idleCycles(8);

    $display("[TB] overflow");
    readyDrv = 1'b0;
    buildGood(1'b1, 16'hA5A5, 32'h01234567);
    sendFrame(8, 1'b1);
    idleCycles(8);
    buildGood(1'b1, 16'h5A5A, 32'h89ABCDEF);
    sendFrame(8, 1'b1);
    checkOutput("ovf_code", 32'(err_code_o), 32'd3);
    checkOutput("ovf_hold_addr", 32'(req_addr_o), 32'hA5A5);
    checkOutput("ovf_hold_data", req_data_o, 32'h01234567);
    idleCycles(4);
    readyDrv = 1'b1;
    idleCycles(2);
    checkOutput("ovf_released", 32'(req_valid_o), 32'd0);
    idleCycles(8);

    $display("[TB] timeout");
    buildRandom(3);
    frm[0] = 8'h80;
    sendFrame(8, 1'b0);
    idleCycles(TO - 1);
    checkOutput("to_not_yet", 32'(err_o), 32'd0);
    idleCycles(1);
    checkOutput("to_err", 32'(err_o), 32'd1);
    checkOutput("to_code", 32'(err_code_o), 32'd4);
    idleCycles(80);
    buildGood(1'b1, 16'hBEEF, 32'hCAFEF00D);
    sendFrame(8, 1'b1);
    checkOutput("after_to_addr", 32'(req_addr_o), 32'hBEEF);
    idleCycles(8);

    $display("[TB] long frame");
    buildGood(1'b1, 16'h0042, 32'h11223344);
    frm.push_back(8'h00);
    sendFrame(8, 1'b1);
    checkOutput("long_code", 32'(err_code_o), 32'd1);
    idleCycles(8);

    $display("[TB] long frame without tlast, discard timeout");
    buildRandom(PLEN + 1);
    sendFrame(8, 1'b0);
    idleCycles(TO + 20);
    checkOutput("discard_to_code", 32'(err_code_o), 32'd1);

    $display("[TB] reset mid-packet");
    readyDrv = 1'b0;
    buildGood(1'b1, 16'h7777, 32'h76543210);
    sendFrame(8, 1'b1);
    idleCycles(7);
    buildGood(1'b1, 16'h3333, 32'h33333333);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(frm[i], 1'b1, 1'b0);
      idleCycles(7);
    end
    rstDrv = 1'b1;
    idleCycles(1);
    rstDrv = 1'b0;
    checkOutput("midrst_valid", 32'(req_valid_o), 32'd0);
    checkOutput("midrst_addr", 32'(req_addr_o), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count_o), 32'd0);
    readyDrv = 1'b1;
    for (int i = 0; i < 4; i++) void'(frm.pop_front());
    sendFrame(8, 1'b1);
    idleCycles(8);

    $display("[TB] counter saturation");
    for (int k = 0; k < MAXC + 2; k++) begin
      buildGood(1'($urandom), 16'($urandom), $urandom);
      sendFrame(8, 1'b1);
      idleCycles(7);
    end
    checkOutput("pkt_sat", 32'(pkt_count_o), 32'(MAXC));
    for (int k = 0; k < MAXC + 2; k++) begin
      buildRandom(1);
      sendFrame(8, 1'b1);
      idleCycles(7);
    end
    checkOutput("err_sat", 32'(err_count_o), 32'(MAXC));

    $display("[TB] random frames");
    rstDrv = 1'b1;
    idleCycles(1);
    rstDrv = 1'b0;
    randReady = 1'b1;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 5);
      if (kind <= 2) begin
        buildGood(1'($urandom), 16'($urandom), $urandom);
        if ($urandom_range(0, 9) == 0) frm[0] = frm[0] | 8'h08;
      end else if (kind == 3) begin
        buildGood(1'($urandom), 16'($urandom), $urandom);
        frm[$urandom_range(1, PLEN - 1)] ^= 8'($urandom_range(1, 255));
      end else if (kind == 4) begin
        buildRandom($urandom_range(1, PLEN - 1));
      end else begin
        buildRandom($urandom_range(PLEN + 1, PLEN + 2));
      end
      sendFrame($urandom_range(8, 12), 1'b1);
      idleCycles($urandom_range(7, 20));
    end
    randReady = 1'b0;
    idleCycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode1_cmd_parser.md
Name: mode1_cmd_parser

Overview:
- Downstream consumer of the command decoder's mode1 byte stream (cmdproc_tdata/tvalid/tlast).
- Assembles framed 8-byte packets into 32-bit register read/write requests.
- Holds one request on a valid/ready register-bus port.
- Never stalls upstream. Malformed or unserviceable packets are dropped and counted.

Parameters:
- CNT_WIDTH, 16, width of the saturating good-packet and error counters.
- TIMEOUT, 1023, maximum sysclk cycles between bytes inside a packet before the packet is aborted.

Ports:
- sysclk_i  in  1  system clock, 125 MHz.
- rst_i  in  1  synchronous, active-high reset; driven from the decoder's mode1 reset OR system reset.
- s_tdata  in  8  mode1 byte.
- s_tvalid  in  1  byte strobe; one cycle per byte, at most one byte every 8 cycles.
- s_tlast  in  1  final byte of frame; qualified by s_tvalid.
- s_tready  out  1  constant 1.
- req_valid_o  out  1  request pending.
- req_ready_i  in  1  register bus accepts request.
- req_wr_o  out  1  1 = write, 0 = read.
- req_addr_o  out  16  register address.
- req_data_o  out  32  write data; don't-care for reads.
- err_o  out  1  one-cycle pulse per dropped packet.
- err_code_o  out  3  code of most recent error, held.
- pkt_count_o  out  CNT_WIDTH  accepted packets, saturating.
- err_count_o  out  CNT_WIDTH  dropped packets, saturating.

Behaviour:
- Packet layout:
  - B0: command. Bit 7 = write. Bits 6:0 must be 0; nonzero → checksum-class error (code 2).
  - B1, B2: address, MSB first.
  - B3..B6: data, MSB first.
  - B7: checksum, such that B0+…+B7 ≡ 0 mod 256. Carries tlast.
- FSM states:
  - IDLE: expects B0.
  - HDR: B1–B2.
  - DATA: B3–B6.
  - CKSUM: B7.
  - DISCARD: drop bytes until a tlast byte, then → IDLE.
- A 3-bit byte index and an 8-bit running sum advance on each s_tvalid. Both are cleared on entry to IDLE.
- Error codes:
  - 0 short: tlast on a byte before the final byte. That byte ends the frame; → IDLE.
  - 1 long: final byte without tlast; → DISCARD.
  - 2 checksum: bad sum or reserved bits set; → IDLE.
  - 3 overflow: packet completes while req_valid_o=1 and req_ready_i=0. New packet dropped; pending request untouched.
  - 4 timeout: outside IDLE/DISCARD, TIMEOUT cycles elapse with no s_tvalid; → IDLE. In DISCARD, timeout also → IDLE, with no additional error.
- Each error: err_o pulses for 1 cycle the cycle after detection; err_code_o updates in the same cycle; err_count_o increments. One error per frame maximum.
- Good packet: req_* outputs load and req_valid_o rises the cycle after the B7 beat; pkt_count_o increments in the same cycle.
- req_valid_o stays high until a cycle with req_ready_i=1; it falls on the next edge unless a new packet loads in that same cycle.
- If req_ready_i=1 in the same cycle a packet completes, the slot frees and the new request loads, with no overflow.
- Counters saturate at all-ones; they never wrap.
- Reset values: req_valid_o=0, req_wr_o=0, req_addr_o=0, req_data_o=0, err_o=0, err_code_o=0, counters=0, FSM=IDLE.
- Reset mid-packet discards partial state. Remaining bytes of the interrupted frame are parsed as a new packet and end in a short or checksum error.

Optional Feature:
- Macro: MODE1_CMD_CHECKSUM_EN.
- Defined: 8-byte packets as above, with the checksum check.
- Undefined:
  - Packets are 7 bytes; tlast is on B6, and the CKSUM state and sum logic are removed.
  - Reserved-bit violation still raises code 2.
  - An 8-byte frame raises long error (code 1).

Decomposition:
- Package pueo_mode1_pkg:
  - FSM state enum.
  - Error-code localparams: ERR_SHORT=0, ERR_LONG=1, ERR_CKSUM=2, ERR_OVF=3, ERR_TIMEOUT=4.
  - Packet length constant, conditional on the macro.
  - Bit position of the write flag.
- One sub-module, mode1_sat_counter: parameterised saturating counter with increment enable and synchronous reset, instantiated twice.

Test Plan:
- Write packet: bytes 80 00 10 DE AD BE EF 38 (tlast on 38), 8 cycles apart, req_ready_i=1 → req_valid_o for 1 cycle with wr=1, addr=0x0010, data=0xDEADBEEF; pkt_count_o=1.
- Same packet with last byte 39 → no req_valid_o; err_o pulse; err_code_o=2; err_count_o=1.
- Short frame: 80 00 10 with tlast on 10 → err_code_o=0. A following valid packet is accepted normally.
- Hold req_ready_i=0 and send two good packets → first request held unchanged; err_code_o=3. Raising req_ready_i then completes the first request only.
- Send 3 bytes, then idle 1100 cycles → err_code_o=4 at cycle 1023 after the last byte. Next packet accepted.
- Long frame: 9 bytes with tlast on the 9th → err_code_o=1; exactly one err_o pulse. Assert rst_i mid-packet → outputs return to reset values.
